decoder_3lxnpc_mc: RTL
======================

# decoder_3lxnpc_mc

Multi-channel, parametrised 3-level NPC/NPP/ANPC gate decoder: converts per-channel level commands into 6-switch gate patterns with per-channel dead-time insertion, minimum dwell enforcement and P↔N routing through zero. It adds safe runtime topology changeover and an illegal-command trap. It sits between the modulator and the gate-driver pins, one instance per converter, with N_CH phase legs.

## Interface
- N_CH, 3, number of phase legs
- TDELAY_WIDTH, 16, width of timing inputs and internal counters
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- t_short  in  TDELAY_WIDTH  minimum dwell in any level, cycles
- t_off_on  in  TDELAY_WIDTH  dead time, cycles; also changeover blanking length
- v_lev  in  2*N_CH  per-channel level command; ch i = [2i+1:2i]; 0=N, 1=O, 2=P, 3=illegal
- comm_type_anpc  in  _commtypes_t  ANPC zero-state variant: OU, OL, OB
- npc_type  in  _npctypes_t  requested topology: NPC, NPP, ANPC
- S_out  out  6*N_CH  gate outputs; ch i = [6i+5:6i], bit0=S1 … bit5=S6
- type_active  out  _npctypes_t  topology currently driving S_out
- busy  out  1  topology changeover in progress
- fault  out  N_CH  sticky illegal-command flag per channel

## Operation
- Patterns, bit5..bit0: NPC P=000011, O=000110, N=001100; NPP P=000101, O=000110, N=001010; ANPC P=100011, N=011100, O: OU=010010, OL=100100, OB=110110.
- Per-channel FSM: STARTUP → HOLD ↔ DEAD. Registers: cur level, nxt level, dwell counter, dead counter, latched ANPC O-variant.
- STARTUP: S_out=0 for max(t_off_on,1) cycles, then HOLD with cur=O, dwell=0.
- HOLD: S_out=pattern(cur); dwell increments, saturates at all-ones. Request accepted when target≠cur and dwell≥t_short; nxt=target if adjacent, else O (P↔N always passes through O, which is held ≥t_short).
- DEAD: S_out=pattern(cur) AND pattern(nxt); lasts max(t_off_on,1) cycles; then cur=nxt, dwell=0, HOLD.
- ANPC O-variant latched on DEAD entry when nxt=O; comm_type_anpc changes while in O take effect on next O entry only.
- v_lev=3: fault[i] set (cleared by reset only); target treated as O.
- Targets changing mid-DEAD are ignored until HOLD; re-evaluated against dwell.
- Changeover (npc_type≠type_active, sampled in HOLD): busy=1; all channel targets forced to O. When every channel is HOLD, cur=O, dwell≥t_short: all S_out=0 for max(t_off_on,1) cycles (BLANK), then type_active=npc_type, busy=0, channels resume HOLD at O with dwell=0. npc_type changes during changeover: latest value loaded at BLANK end; if it equals old type, BLANK still completes.
- Reset (any cycle, incl. mid-DEAD/BLANK): S_out=0, fault=0, busy=0, type_active=npc_type sampled at reset, all channels STARTUP.

## Timing
- All outputs registered. Request sampled at edge k → dead pattern visible after edge k; new pattern after edge k+max(t_off_on,1).
- Acceptance earliest at first HOLD cycle when t_short=0.
- Changeover completes after the slowest channel's O dwell plus blanking; no cycle ever shows patterns of two topologies on one channel.

## Configuration
- DECODER_XNPC_CHG_EN defined: runtime changeover as above.
- Undefined: type_active fixed to npc_type sampled during reset; later npc_type changes ignored; busy tied 0; no BLANK state synthesised.

## Structure
- PKG_decoder_3lxnpc: existing _npctypes_t, _commtypes_t; add level enum (LEV_N, LEV_O, LEV_P, LEV_ILL), channel state enum, all pattern constants, pattern lookup function.
- Sub-module decoder_3lxnpc_ch: one-leg FSM, generated N_CH times; top holds type register, changeover FSM, fault collation.

## Test plan
- NPC, t_off_on=4, t_short=10, ch0 O→P after dwell: S_out[5:0] 000110 → 000010 ×4 cycles → 000011.
- NPC ch1 P→N: 000011 → 000010 ×4 → 000110 ≥10 cycles → 000100 ×4 → 001100.
- Dwell: ch0 O→P→O toggled 3 cycles apart: O re-entry deferred until dwell=10.
- v_lev ch2=3 while P: fault=3'b100, ch2 goes to O via dead time; fault held after v_lev=0.
- NPC→ANPC, OL: busy=1, all legs to 000110, S_out=0 ×4, type_active=ANPC, legs at 100100, busy=0.
- Reset asserted mid-DEAD: next cycle S_out=0, fault=0, busy=0; O reached after 4 STARTUP cycles.

Source files
------------

// File: rtl/decoder_3lxnpc_mc_pkg.sv
// Package for the multi-channel 3-level NPC/NPP/ANPC gate decoder.
// Holds the topology and ANPC zero-state type definitions, the level and
// FSM state enums, the gate pattern constants and the pattern lookup.
// Pattern bit order: bit0=S1 ... bit5=S6.
package PKG_decoder_3lxnpc;

   typedef enum logic [1:0] {NPC = 2'd0, NPP = 2'd1, ANPC = 2'd2} _npctypes_t;
   typedef enum logic [1:0] {OU = 2'd0, OL = 2'd1, OB = 2'd2} _commtypes_t;

   typedef enum logic [1:0] {LEV_N = 2'd0, LEV_O = 2'd1, LEV_P = 2'd2, LEV_ILL = 2'd3} lev_t;
   typedef enum logic [1:0] {CH_STARTUP = 2'd0, CH_HOLD = 2'd1, CH_DEAD = 2'd2} ch_state_t;
   typedef enum logic [1:0] {CHG_IDLE = 2'd0, CHG_WAIT = 2'd1, CHG_BLANK = 2'd2} chg_state_t;

   localparam logic [5:0] NPC_P   = 6'b000011;
   localparam logic [5:0] NPC_O   = 6'b000110;
   localparam logic [5:0] NPC_N   = 6'b001100;
   localparam logic [5:0] NPP_P   = 6'b000101;
   localparam logic [5:0] NPP_O   = 6'b000110;
   localparam logic [5:0] NPP_N   = 6'b001010;
   localparam logic [5:0] ANPC_P  = 6'b100011;
   localparam logic [5:0] ANPC_N  = 6'b011100;
   localparam logic [5:0] ANPC_OU = 6'b010010;
   localparam logic [5:0] ANPC_OL = 6'b100100;
   localparam logic [5:0] ANPC_OB = 6'b110110;

   // Gate pattern for a topology / level / ANPC zero variant.
   // Anything undefined (illegal level or topology code) yields all-off.
   function automatic logic [5:0] pattern(input _npctypes_t t, input lev_t l,
                                          input _commtypes_t c);
      logic [5:0] p;
      p = 6'b000000;
      case (t)
         NPC: begin
            case (l)
               LEV_P:   p = NPC_P;
               LEV_O:   p = NPC_O;
               LEV_N:   p = NPC_N;
               default: p = 6'b000000;
            endcase
         end
         NPP: begin
            case (l)
               LEV_P:   p = NPP_P;
               LEV_O:   p = NPP_O;
               LEV_N:   p = NPP_N;
               default: p = 6'b000000;
            endcase
         end
         ANPC: begin
            case (l)
               LEV_P: p = ANPC_P;
               LEV_N: p = ANPC_N;
               LEV_O: begin
                  case (c)
                     OU:      p = ANPC_OU;
                     OL:      p = ANPC_OL;
                     OB:      p = ANPC_OB;
                     default: p = 6'b000000;
                  endcase
               end
               default: p = 6'b000000;
            endcase
         end
         default: p = 6'b000000;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/decoder_3lxnpc_mc_ch.sv
// One phase leg of the 3-level gate decoder.
// FSM STARTUP -> HOLD <-> DEAD with dead-time insertion, minimum dwell and
// P<->N routing through O.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   t_short, t_off_on minimum dwell and dead time (cycles)
//   target            requested level (already mapped to N/O/P)
//   ptype             topology currently driving the gates
//   comm              ANPC zero-state variant, latched on each O entry
//   blank             force gates off and freeze the leg (changeover blanking)
//   restart           re-enter HOLD at O with dwell 0 under restart_type
//   gates             registered 6-bit gate pattern
//   ready             (changeover build) leg is settled at O with dwell met
module decoder_3lxnpc_ch
   import PKG_decoder_3lxnpc::*;
#(
   parameter int TDELAY_WIDTH = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TDELAY_WIDTH-1:0] t_short,
   input  logic [TDELAY_WIDTH-1:0] t_off_on,
   input  lev_t                    target,
   input  _npctypes_t              ptype,
   input  _commtypes_t             comm,
   input  logic                    blank,
   input  logic                    restart,
   input  _npctypes_t              restart_type,
   output logic [5:0]              gates
`ifdef DECODER_XNPC_CHG_EN
   ,
   output logic                    ready
`endif
);

   ch_state_t               state;
   lev_t                    cur;
   lev_t                    nxt;
   _commtypes_t             ovar;
   logic [TDELAY_WIDTH-1:0] dwell;
   logic [TDELAY_WIDTH-1:0] cnt;
   logic [TDELAY_WIDTH-1:0] dly;
   lev_t                    nxt_sel;
   _commtypes_t             ov_sel;
   logic                    accept;

   always_comb begin
      // A zero dead time still costs one cycle.
      dly     = (t_off_on == '0) ? TDELAY_WIDTH'(1) : t_off_on;
      // From O any target is adjacent; from P or N the only way out is O.
      nxt_sel = (cur == LEV_O) ? target : LEV_O;
      ov_sel  = (nxt_sel == LEV_O) ? comm : ovar;
      accept  = (state == CH_HOLD) && (target != cur) && (dwell >= t_short);
   end

`ifdef DECODER_XNPC_CHG_EN
   assign ready = (state == CH_HOLD) && (cur == LEV_O) && (dwell >= t_short);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= CH_STARTUP;
         cur   <= LEV_O;
         nxt   <= LEV_O;
         ovar  <= OU;
         dwell <= '0;
         cnt   <= TDELAY_WIDTH'(1);
         gates <= 6'b000000;
      end else if (restart) begin
         state <= CH_HOLD;
         cur   <= LEV_O;
         ovar  <= comm;
         dwell <= '0;
         gates <= pattern(restart_type, LEV_O, comm);
      end else if (blank) begin
         gates <= 6'b000000;
      end else begin
         case (state)
            CH_STARTUP: begin
               if (cnt >= dly) begin
                  state <= CH_HOLD;
                  cur   <= LEV_O;
                  ovar  <= comm;
                  dwell <= '0;
                  gates <= pattern(ptype, LEV_O, comm);
               end else begin
                  cnt <= cnt + TDELAY_WIDTH'(1);
               end
            end
            CH_HOLD: begin
               if (accept) begin
                  state <= CH_DEAD;
                  nxt   <= nxt_sel;
                  ovar  <= ov_sel;
                  cnt   <= TDELAY_WIDTH'(1);
                  // Only switches common to both levels stay on.
                  gates <= pattern(ptype, cur, ovar) & pattern(ptype, nxt_sel, ov_sel);
               end else begin
                  if (dwell != '1) dwell <= dwell + TDELAY_WIDTH'(1);
                  gates <= pattern(ptype, cur, ovar);
               end
            end
            CH_DEAD: begin
               if (cnt >= dly) begin
                  state <= CH_HOLD;
                  cur   <= nxt;
                  dwell <= '0;
                  gates <= pattern(ptype, nxt, ovar);
               end else begin
                  cnt <= cnt + TDELAY_WIDTH'(1);
               end
            end
            default: state <= CH_STARTUP;
         endcase
      end
   end

endmodule

// File: rtl/decoder_3lxnpc_mc.sv
// Multi-channel 3-level NPC/NPP/ANPC gate decoder top.
// Instantiates N_CH leg FSMs, maps illegal commands to O with a sticky fault
// flag, and owns the active-topology register.
// Optional feature macro: DECODER_XNPC_CHG_EN enables safe runtime topology
// changeover (all legs to O, blanking, then switch). Without it the topology
// is fixed to npc_type sampled during reset and busy is 0.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   t_short         minimum dwell per level (cycles)
//   t_off_on        dead time and blanking length (cycles, 0 acts as 1)
//   v_lev           per-channel level command, ch i = [2i+1:2i]
//   comm_type_anpc  ANPC zero-state variant
//   npc_type        requested topology
//   S_out           gate outputs, ch i = [6i+5:6i]
//   type_active     topology currently driving S_out
//   busy            changeover in progress
//   fault           sticky per-channel illegal-command flag
module decoder_3lxnpc_mc
   import PKG_decoder_3lxnpc::*;
#(
   parameter int N_CH         = 3,
   parameter int TDELAY_WIDTH = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TDELAY_WIDTH-1:0] t_short,
   input  logic [TDELAY_WIDTH-1:0] t_off_on,
   input  logic [2*N_CH-1:0]       v_lev,
   input  _commtypes_t             comm_type_anpc,
   input  _npctypes_t              npc_type,
   output logic [6*N_CH-1:0]       S_out,
   output _npctypes_t              type_active,
   output logic                    busy,
   output logic [N_CH-1:0]         fault
);

   logic [N_CH-1:0] ill;
   lev_t            target [N_CH];
   logic            force_o;
   logic            blank;
   logic            restart;
   _npctypes_t      restart_type;
`ifdef DECODER_XNPC_CHG_EN
   logic [N_CH-1:0] ready;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign ill[i]    = (v_lev[2*i +: 2] == 2'd3);
      assign target[i] = (ill[i] || force_o) ? LEV_O : lev_t'(v_lev[2*i +: 2]);

      decoder_3lxnpc_ch #(.TDELAY_WIDTH(TDELAY_WIDTH)) u_ch (
         .clk          (clk),
         .rst          (rst),
         .t_short      (t_short),
         .t_off_on     (t_off_on),
         .target       (target[i]),
         .ptype        (type_active),
         .comm         (comm_type_anpc),
         .blank        (blank),
         .restart      (restart),
         .restart_type (restart_type),
         .gates        (S_out[6*i +: 6])
`ifdef DECODER_XNPC_CHG_EN
         ,
         .ready        (ready[i])
`endif
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) fault <= '0;
      else      fault <= fault | ill;
   end

`ifdef DECODER_XNPC_CHG_EN
   chg_state_t              chg_state;
   logic [TDELAY_WIDTH-1:0] bcnt;
   logic [TDELAY_WIDTH-1:0] dly;
   logic                    all_ready;
   logic                    blank_done;

   always_comb begin
      dly          = (t_off_on == '0) ? TDELAY_WIDTH'(1) : t_off_on;
      all_ready    = &ready;
      blank_done   = (chg_state == CHG_BLANK) && (bcnt >= dly);
      force_o      = (chg_state != CHG_IDLE);
      // Legs go dark on the same edge the changeover enters BLANK.
      blank        = ((chg_state == CHG_WAIT) && all_ready) ||
                     ((chg_state == CHG_BLANK) && !blank_done);
      restart      = blank_done;
      // Whatever is requested at the end of blanking becomes active.
      restart_type = npc_type;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         chg_state   <= CHG_IDLE;
         type_active <= npc_type;
         busy        <= 1'b0;
         bcnt        <= TDELAY_WIDTH'(1);
      end else begin
         case (chg_state)
            CHG_IDLE: begin
               if (npc_type != type_active) begin
                  chg_state <= CHG_WAIT;
                  busy      <= 1'b1;
               end
            end
            CHG_WAIT: begin
               if (all_ready) begin
                  chg_state <= CHG_BLANK;
                  bcnt      <= TDELAY_WIDTH'(1);
               end
            end
            CHG_BLANK: begin
               if (blank_done) begin
                  chg_state   <= CHG_IDLE;
                  type_active <= npc_type;
                  busy        <= 1'b0;
               end else begin
                  bcnt <= bcnt + TDELAY_WIDTH'(1);
               end
            end
            default: chg_state <= CHG_IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst) type_active <= npc_type;
   end

   assign busy         = 1'b0;
   assign force_o      = 1'b0;
   assign blank        = 1'b0;
   assign restart      = 1'b0;
   assign restart_type = type_active;
`endif

endmodule
